vliw_spi_master: RTL and testbench

Parametrised SPI master that replaces the fixed 8-bit, mode-0-only SPI engine used by the VLIW core's I/O unit. It adds configurable word width, all four clock modes (CPOL/CPHA), per-transfer MSB/LSB-first ordering and optional chip-select generation. The block sits between the I/O register file and the SPI pads, and runs one full-duplex transfer per `start`.

---
 rtl/vliw_spi_pkg.sv | 15 +
 rtl/vliw_spi_clkgen.sv | 32 +++
 rtl/vliw_spi_master.sv | 167 ++++++++++++++++
 tb/tb_vliw_spi_master.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vliw_spi_pkg.sv
// vliw_spi_pkg: state encoding and mode bit positions shared by
// the vliw_spi_master block and its clock generator.
package vliw_spi_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LEAD,
      SHIFT,
      TRAIL
   } state_t;

   localparam int CPOL_BIT = 1;
   localparam int CPHA_BIT = 0;

endpackage

// File: rtl/vliw_spi_clkgen.sv
// vliw_spi_clkgen: half-period tick generator. The divisor is captured
// on clr so a transfer runs at a fixed rate whatever the live input does.
module vliw_spi_clkgen #(
   parameter int DIV_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic [DIV_W-1:0] divisor,
   output logic             tick
);

   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] div_l;

   assign tick = (cnt == div_l);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt   <= '0;
         div_l <= '0;
      end else if (clr) begin
         cnt   <= '0;
         div_l <= divisor;
      end else if (tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + DIV_W'(1);
      end
   end

endmodule

// File: rtl/vliw_spi_master.sv
// vliw_spi_master: parametrised full-duplex SPI master, CPOL/CPHA modes,
// MSB/LSB order. Define VLIW_SPI_CS_EN for chip selects with setup/hold.
module vliw_spi_master
   import vliw_spi_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIV_W = 8,
   parameter int NCS   = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [DIV_W-1:0] divisor,
   input  logic [1:0]       mode,
   input  logic             lsb_first,
   input  logic [WIDTH-1:0] din,
   input  logic             start,
   output logic [WIDTH-1:0] dout,
   output logic             busy,
   output logic             done,
   input  logic             DI,
`ifdef VLIW_SPI_CS_EN
   input  logic [((NCS > 1) ? $clog2(NCS) : 1)-1:0] cs_sel,
   input  logic             hold_cs,
   output logic [NCS-1:0]   CS_N,
`endif
   output logic             SCLK,
   output logic             DO
);

   localparam int EW = $clog2(2 * WIDTH);
   localparam logic [EW-1:0] LAST = EW'(2 * WIDTH - 1);

   state_t           state;
   state_t           state_nx;
   logic             tick;
   logic             accept;
   logic             sh_tick;
   logic             lead_edge;
   logic             last;
   logic             sample;
   logic             present;
   logic             finish;
   logic             tx_bit;
   logic [WIDTH-1:0] tx_sr;
   logic [WIDTH-1:0] rx_sr;
   logic [WIDTH-1:0] rx_nx;
   logic [EW-1:0]    ecnt;
   logic [1:0]       mode_l;
   logic             lsb_l;
`ifdef VLIW_SPI_CS_EN
   logic             hold_l;
`endif

   function automatic logic [WIDTH-1:0] shift_out(
      input logic [WIDTH-1:0] v,
      input logic             lsb
   );
      return lsb ? (v >> 1) : (v << 1);
   endfunction

   vliw_spi_clkgen #(.DIV_W(DIV_W)) u_clkgen (
      .clk     (clk),
      .rst     (rst),
      .clr     (accept),
      .divisor (divisor),
      .tick    (tick)
   );

   // a start coinciding with done is dropped so done is never masked
   assign accept    = (state == IDLE) && start && !done;
   assign sh_tick   = (state == SHIFT) && tick;
   assign lead_edge = ~ecnt[0];
   assign last      = (ecnt == LAST);
   assign sample    = sh_tick && (lead_edge ^ mode_l[CPHA_BIT]);
   assign present   = sh_tick && !(lead_edge ^ mode_l[CPHA_BIT]) && !last;
   assign tx_bit    = lsb_l ? tx_sr[0] : tx_sr[WIDTH-1];
   assign rx_nx     = lsb_l ? {DI, rx_sr[WIDTH-1:1]}
                            : {rx_sr[WIDTH-2:0], DI};
`ifdef VLIW_SPI_CS_EN
   assign finish    = (state == TRAIL) && tick;
`else
   assign finish    = sh_tick && last;
`endif

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
`ifdef VLIW_SPI_CS_EN
         IDLE:    if (accept) state_nx = LEAD;
         SHIFT:   if (sh_tick && last) state_nx = TRAIL;
`else
         IDLE:    if (accept) state_nx = SHIFT;
         SHIFT:   if (sh_tick && last) state_nx = IDLE;
`endif
         LEAD:    if (tick) state_nx = SHIFT;
         TRAIL:   if (tick) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dout   <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         SCLK   <= 1'b0;
         DO     <= 1'b0;
         tx_sr  <= '0;
         rx_sr  <= '0;
         ecnt   <= '0;
         mode_l <= '0;
         lsb_l  <= 1'b0;
`ifdef VLIW_SPI_CS_EN
         hold_l <= 1'b0;
         CS_N   <= '1;
`endif
      end else begin
         done <= 1'b0;
         if (state == IDLE) begin
            SCLK <= mode[CPOL_BIT];
            DO   <= 1'b0;
         end
         if (accept) begin
            busy   <= 1'b1;
            mode_l <= mode;
            lsb_l  <= lsb_first;
            rx_sr  <= '0;
            ecnt   <= '0;
            // CPHA=0 has its first bit on the wire before any edge
            if (!mode[CPHA_BIT]) begin
               DO    <= lsb_first ? din[0] : din[WIDTH-1];
               tx_sr <= shift_out(din, lsb_first);
            end else begin
               tx_sr <= din;
            end
`ifdef VLIW_SPI_CS_EN
            hold_l <= hold_cs;
            CS_N   <= ~(NCS'(1) << cs_sel);
`endif
         end
         if (sh_tick) begin
            SCLK <= ~SCLK;
            ecnt <= ecnt + EW'(1);
         end
         if (state == TRAIL) SCLK <= mode_l[CPOL_BIT];
         if (sample) rx_sr <= rx_nx;
         if (present) begin
            DO    <= tx_bit;
            tx_sr <= shift_out(tx_sr, lsb_l);
         end
         if (finish) begin
            dout <= sample ? rx_nx : rx_sr;
            done <= 1'b1;
            busy <= 1'b0;
`ifdef VLIW_SPI_CS_EN
            if (!hold_l) CS_N <= '1;
`endif
         end
      end
   end

endmodule

// File: tb/tb_vliw_spi_master.sv
// tb_vliw_spi_master: directed checks of vliw_spi_master, 8-bit and
// 16-bit instances; CS scenarios run when VLIW_SPI_CS_EN is defined.
module tb_vliw_spi_master;

   localparam int NCS = 4;
`ifdef VLIW_SPI_CS_EN
   localparam int EXTRA = 2;
`else
   localparam int EXTRA = 0;
`endif

   int checks = 0;
   int errors = 0;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   logic [7:0]  div8;
   logic [1:0]  mode8;
   logic        lsb8;
   logic [7:0]  din8;
   logic        start8;
   logic [7:0]  dout8;
   logic        busy8, done8, sclk8, do8, di8;
`ifdef VLIW_SPI_CS_EN
   logic [1:0]  sel8;
   logic        hold8;
   logic [3:0]  csn8;
   logic [0:0]  sel16;
   logic        hold16;
   logic [0:0]  csn16;
`endif

   logic [7:0]  div16;
   logic [1:0]  mode16;
   logic        lsb16;
   logic [15:0] din16;
   logic        start16;
   logic [15:0] dout16;
   logic        busy16, done16, sclk16, do16;

   logic        slave_en = 1'b0;
   logic        s_di = 1'b0;
   logic [7:0]  s_word = '0;
   assign di8 = slave_en ? s_di : do8;

   // slave for CPHA=1: presents its next bit on each leading edge
   always @(negedge sclk8)
      if (slave_en) begin
         s_di   = s_word[7];
         s_word = {s_word[6:0], 1'b0};
      end

   logic        cap_en = 1'b0;
   logic        cap_lvl = 1'b1;
   logic [15:0] cap_bits;
   int          cap_n;
   always @(sclk8)
      if (cap_en && sclk8 === cap_lvl && cap_n < 16) begin
         cap_bits[cap_n] = do8;
         cap_n++;
      end

   logic        cap16_en = 1'b0;
   logic [15:0] cap16;
   int          cap16_n;
   always @(posedge sclk16)
      if (cap16_en && cap16_n < 16) begin
         cap16[cap16_n] = do16;
         cap16_n++;
      end

   vliw_spi_master #(.WIDTH(8), .DIV_W(8), .NCS(NCS)) dut8 (
      .clk(clk), .rst(rst), .divisor(div8), .mode(mode8),
      .lsb_first(lsb8), .din(din8), .start(start8), .dout(dout8),
      .busy(busy8), .done(done8), .DI(di8),
`ifdef VLIW_SPI_CS_EN
      .cs_sel(sel8), .hold_cs(hold8), .CS_N(csn8),
`endif
      .SCLK(sclk8), .DO(do8)
   );

   vliw_spi_master #(.WIDTH(16), .DIV_W(8), .NCS(1)) dut16 (
      .clk(clk), .rst(rst), .divisor(div16), .mode(mode16),
      .lsb_first(lsb16), .din(din16), .start(start16), .dout(dout16),
      .busy(busy16), .done(done16), .DI(do16),
`ifdef VLIW_SPI_CS_EN
      .cs_sel(sel16), .hold_cs(hold16), .CS_N(csn16),
`endif
      .SCLK(sclk16), .DO(do16)
   );

   // runs one transfer on dut8; cyc is the cycle of done (-1 on timeout)
   task automatic xfer8(
      input  logic [7:0] d, input logic [1:0] m, input logic l,
      input  logic [7:0] data, input logic [1:0] sel, input logic hold,
      input  int pulse_at, output int cyc, output logic b1,
      output logic [3:0] cs_and, output logic [3:0] cs_or
   );
      @(negedge clk);
      div8 = d; mode8 = m; lsb8 = l; din8 = data; start8 = 1'b1;
`ifdef VLIW_SPI_CS_EN
      sel8 = sel; hold8 = hold;
`else
      if (sel != 2'd0 || hold) $display("note: CS inputs unused in this build");
`endif
      @(posedge clk); #1;
      start8 = 1'b0;
      cyc = -1; b1 = 1'b0; cs_and = '1; cs_or = '0;
      for (int i = 1; i <= 4000; i++) begin
         if (i == pulse_at) begin
            start8 = 1'b1; din8 = 8'hFF;
         end else begin
            start8 = 1'b0;
         end
         @(posedge clk); #1;
         if (i == 1) b1 = busy8;
         if (done8) begin
            cyc = i;
            break;
         end
`ifdef VLIW_SPI_CS_EN
         cs_and = cs_and & csn8;
         cs_or  = cs_or | csn8;
`endif
      end
      start8 = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; mode8 = 2'b10;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (dout8 !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h want 00", dout8); end
      checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy8); end
      checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done8); end
      checks++; if (sclk8 !== 1'b0) begin errors++; $display("FAIL reset_sclk: got %b want 0", sclk8); end
      checks++; if (do8 !== 1'b0) begin errors++; $display("FAIL reset_do: got %b want 0", do8); end
      checks++; if (dout16 !== 16'h0000) begin errors++; $display("FAIL reset_dout16: got %h want 0000", dout16); end
`ifdef VLIW_SPI_CS_EN
      checks++; if (csn8 !== 4'b1111) begin errors++; $display("FAIL reset_csn: got %b want 1111", csn8); end
`endif
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      checks++; if (sclk8 !== 1'b1) begin errors++; $display("FAIL idle_sclk_cpol1: got %b want 1", sclk8); end
      @(negedge clk); mode8 = 2'b00;
      repeat (2) @(posedge clk);
   endtask

   task automatic test_loopback_mode0();
      int cyc; logic b1; logic [3:0] ca, co; logic [7:0] w;
      cap_lvl = 1'b1; cap_n = 0; cap_bits = '0; cap_en = 1'b1;
      xfer8(8'd0, 2'b00, 1'b0, 8'hA5, 2'd0, 1'b0, 0, cyc, b1, ca, co);
      cap_en = 1'b0;
      for (int i = 0; i < 8; i++) w[7-i] = cap_bits[i];
      checks++; if (dout8 !== 8'hA5) begin errors++; $display("FAIL m0_dout: got %h want a5", dout8); end
      checks++; if (cyc !== 16 + EXTRA) begin errors++; $display("FAIL m0_done_cycle: got %0d want %0d", cyc, 16 + EXTRA); end
      checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL m0_busy_c1: got %b want 1", b1); end
      checks++; if (cap_n !== 8) begin errors++; $display("FAIL m0_edges: got %0d want 8", cap_n); end
      checks++; if (w !== 8'hA5) begin errors++; $display("FAIL m0_do_order: got %h want a5", w); end
      checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL m0_busy_at_done: got %b want 0", busy8); end
      @(posedge clk); #1;
      checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL m0_done_pulse: got %b want 0", done8); end
   endtask

   task automatic test_mode3_slave();
      int cyc; logic b1; logic [3:0] ca, co;
      @(negedge clk); mode8 = 2'b11;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (sclk8 !== 1'b1) begin errors++; $display("FAIL m3_idle_sclk: got %b want 1", sclk8); end
      s_word = 8'h3C; s_di = 1'b0; slave_en = 1'b1;
      xfer8(8'd3, 2'b11, 1'b0, 8'h00, 2'd0, 1'b0, 0, cyc, b1, ca, co);
      slave_en = 1'b0;
      checks++; if (dout8 !== 8'h3C) begin errors++; $display("FAIL m3_dout: got %h want 3c", dout8); end
      checks++; if (cyc !== (16 + EXTRA) * 4) begin errors++; $display("FAIL m3_done_cycle: got %0d want %0d", cyc, (16 + EXTRA) * 4); end
      checks++; if (sclk8 !== 1'b1) begin errors++; $display("FAIL m3_end_sclk: got %b want 1", sclk8); end
      @(negedge clk); mode8 = 2'b00;
      repeat (2) @(posedge clk);
   endtask

   task automatic test_lsb_mode1();
      int cyc; logic b1; logic [3:0] ca, co; logic [7:0] w;
      @(negedge clk); mode8 = 2'b01;
      repeat (2) @(posedge clk);
      cap_lvl = 1'b0; cap_n = 0; cap_bits = '0; cap_en = 1'b1;
      xfer8(8'd2, 2'b01, 1'b1, 8'h1E, 2'd0, 1'b0, 0, cyc, b1, ca, co);
      cap_en = 1'b0;
      for (int i = 0; i < 8; i++) w[i] = cap_bits[i];
      checks++; if (dout8 !== 8'h1E) begin errors++; $display("FAIL m1_lsb_dout: got %h want 1e", dout8); end
      checks++; if (w !== 8'h1E) begin errors++; $display("FAIL m1_lsb_do_order: got %h want 1e", w); end
      checks++; if (cyc !== (16 + EXTRA) * 3) begin errors++; $display("FAIL m1_done_cycle: got %0d want %0d", cyc, (16 + EXTRA) * 3); end
      @(negedge clk); mode8 = 2'b00;
      repeat (2) @(posedge clk);
   endtask

   task automatic test_lsb16();
      int cyc;
      cap16_n = 0; cap16 = '0; cap16_en = 1'b1;
      @(negedge clk);
      div16 = 8'd1; mode16 = 2'b00; lsb16 = 1'b1; din16 = 16'h0001; start16 = 1'b1;
      @(posedge clk); #1;
      start16 = 1'b0; cyc = -1;
      for (int i = 1; i <= 4000; i++) begin
         @(posedge clk); #1;
         if (done16) begin
            cyc = i;
            break;
         end
      end
      cap16_en = 1'b0;
      checks++; if (cap16_n !== 16) begin errors++; $display("FAIL w16_edges: got %0d want 16", cap16_n); end
      checks++; if (cap16[0] !== 1'b1) begin errors++; $display("FAIL w16_first_bit: got %b want 1", cap16[0]); end
      checks++; if (cap16[15:1] !== 15'h0) begin errors++; $display("FAIL w16_rest_bits: got %h want 0", cap16[15:1]); end
      checks++; if (dout16 !== 16'h0001) begin errors++; $display("FAIL w16_dout: got %h want 0001", dout16); end
      checks++; if (cyc !== (32 + EXTRA) * 2) begin errors++; $display("FAIL w16_done_cycle: got %0d want %0d", cyc, (32 + EXTRA) * 2); end
   endtask

   task automatic test_ignore_start();
      int cyc; logic b1; logic [3:0] ca, co; int nbusy;
      xfer8(8'd1, 2'b00, 1'b0, 8'h5A, 2'd0, 1'b0, 5, cyc, b1, ca, co);
      checks++; if (cyc !== (16 + EXTRA) * 2) begin errors++; $display("FAIL ign_done_cycle: got %0d want %0d", cyc, (16 + EXTRA) * 2); end
      checks++; if (dout8 !== 8'h5A) begin errors++; $display("FAIL ign_dout: got %h want 5a", dout8); end
      checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL ign_busy_c1: got %b want 1", b1); end
      nbusy = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (busy8 || done8) nbusy++;
      end
      checks++; if (nbusy !== 0) begin errors++; $display("FAIL ign_no_queue: got %0d busy cycles want 0", nbusy); end
   endtask

   task automatic test_back_to_back();
      int cyc; logic b1; logic [3:0] ca, co;
      xfer8(8'd0, 2'b00, 1'b0, 8'hC3, 2'd0, 1'b0, 0, cyc, b1, ca, co);
      checks++; if (dout8 !== 8'hC3) begin errors++; $display("FAIL b2b_first_dout: got %h want c3", dout8); end
      @(negedge clk); start8 = 1'b1; din8 = 8'h11;
      @(posedge clk); #1; start8 = 1'b0;
      checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL b2b_start_on_done: got busy %b want 0", busy8); end
      xfer8(8'd0, 2'b00, 1'b0, 8'h81, 2'd0, 1'b0, 0, cyc, b1, ca, co);
      checks++; if (cyc !== 16 + EXTRA) begin errors++; $display("FAIL b2b_done_cycle: got %0d want %0d", cyc, 16 + EXTRA); end
      checks++; if (dout8 !== 8'h81) begin errors++; $display("FAIL b2b_second_dout: got %h want 81", dout8); end
   endtask

`ifdef VLIW_SPI_CS_EN
   task automatic test_hold_cs();
      int cyc; logic b1; logic [3:0] ca, co;
      xfer8(8'd0, 2'b00, 1'b0, 8'h96, 2'd2, 1'b1, 0, cyc, b1, ca, co);
      checks++; if (ca !== 4'b1011 || co !== 4'b1011) begin errors++; $display("FAIL cs_hold_during: got and %b or %b want 1011", ca, co); end
      repeat (3) @(posedge clk);
      #1;
      checks++; if (csn8 !== 4'b1011) begin errors++; $display("FAIL cs_hold_idle: got %b want 1011", csn8); end
      xfer8(8'd0, 2'b00, 1'b0, 8'h69, 2'd2, 1'b0, 0, cyc, b1, ca, co);
      checks++; if (ca !== 4'b1011 || co !== 4'b1011) begin errors++; $display("FAIL cs_second_during: got and %b or %b want 1011", ca, co); end
      @(posedge clk); #1;
      checks++; if (csn8 !== 4'b1111) begin errors++; $display("FAIL cs_release: got %b want 1111", csn8); end
      xfer8(8'd0, 2'b00, 1'b0, 8'h0F, 2'd0, 1'b1, 0, cyc, b1, ca, co);
      @(posedge clk); #1;
      checks++; if (csn8 !== 4'b1110) begin errors++; $display("FAIL cs_hold0_idle: got %b want 1110", csn8); end
      xfer8(8'd0, 2'b00, 1'b0, 8'hF0, 2'd3, 1'b0, 0, cyc, b1, ca, co);
      checks++; if (ca !== 4'b0111 || co !== 4'b0111) begin errors++; $display("FAIL cs_switch_line: got and %b or %b want 0111", ca, co); end
      @(posedge clk); #1;
      checks++; if (csn8 !== 4'b1111) begin errors++; $display("FAIL cs_switch_release: got %b want 1111", csn8); end
   endtask
`endif

   task automatic test_reset_mid();
      int ndone;
      @(negedge clk); mode8 = 2'b10;
      repeat (2) @(posedge clk);
      @(negedge clk);
      div8 = 8'd1; lsb8 = 1'b0; din8 = 8'hFF; start8 = 1'b1;
      @(posedge clk); #1; start8 = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      checks++; if (dout8 !== 8'h00) begin errors++; $display("FAIL rmid_dout: got %h want 00", dout8); end
      checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b want 0", busy8); end
      checks++; if (sclk8 !== 1'b0) begin errors++; $display("FAIL rmid_sclk: got %b want 0", sclk8); end
      checks++; if (do8 !== 1'b0) begin errors++; $display("FAIL rmid_do: got %b want 0", do8); end
`ifdef VLIW_SPI_CS_EN
      checks++; if (csn8 !== 4'b1111) begin errors++; $display("FAIL rmid_csn: got %b want 1111", csn8); end
`endif
      @(negedge clk); rst = 1'b0;
      ndone = 0;
      repeat (60) begin
         @(posedge clk); #1;
         if (done8 || busy8) ndone++;
      end
      checks++; if (ndone !== 0) begin errors++; $display("FAIL rmid_no_done: got %0d active cycles want 0", ndone); end
   endtask

   initial begin
      rst = 1'b1;
      div8 = '0; mode8 = '0; lsb8 = 1'b0; din8 = '0; start8 = 1'b0;
      div16 = '0; mode16 = '0; lsb16 = 1'b0; din16 = '0; start16 = 1'b0;
`ifdef VLIW_SPI_CS_EN
      sel8 = '0; hold8 = 1'b0; sel16 = '0; hold16 = 1'b0;
`endif
      test_reset();
      test_loopback_mode0();
      test_mode3_slave();
      test_lsb_mode1();
      test_lsb16();
      test_ignore_start();
      test_back_to_back();
`ifdef VLIW_SPI_CS_EN
      test_hold_cs();
`endif
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
